// File: rtl/bus_pkg.sv
// ---------------------------------------------------------------------------
// bus_pkg
// Shared definitions for the memory-bus responder: data bus width, request
// opcode, responder FSM states, read-data source select and MMIO register
// offsets within the 16-byte MMIO window.
// ---------------------------------------------------------------------------
package bus_pkg;

    localparam int BUS_W = 32;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_e;

    // Where the RESP-cycle read data comes from. Decided when RESP is
    // entered so the bus mux only depends on registered state.
    typedef enum logic [1:0] {
        SRC_RAM  = 2'd0,
        SRC_MMIO = 2'd1,
        SRC_ZERO = 2'd2
    } rsrc_e;

    // Byte offsets inside the MMIO window.
    localparam logic [3:0] MMIO_LED = 4'h0;
    localparam logic [3:0] MMIO_SW  = 4'h4;
    localparam logic [3:0] MMIO_CYC = 4'h8;

endpackage

// File: rtl/bus_mmio_regs.sv
// ---------------------------------------------------------------------------
// bus_mmio_regs
// Memory-mapped registers behind the bus responder.
//   LED  (+0x0) R/W, 16 bits, drives the board LEDs.
//   SW   (+0x4) RO, board switches after a two-flop synchroniser.
//   CYC  (+0x8) free-running 32-bit cycle counter; any write clears it.
//   +0xC reads 0, writes ignored.
// Ports:
//   clk, rst  clock and asynchronous active-high reset
//   wr_en     commit a write this cycle to the register chosen by wr_sel
//   wr_sel    byte offset of the write target
//   wdata     write data (only the LED register keeps data bits)
//   rd_sel    byte offset of the register shown on rdata
//   rdata     combinational read data for rd_sel
//   sw        raw switch inputs
//   led       LED register output
// ---------------------------------------------------------------------------
module bus_mmio_regs
    import bus_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [3:0]       wr_sel,
    input  logic [15:0]      wdata,
    input  logic [3:0]       rd_sel,
    output logic [BUS_W-1:0] rdata,
    input  logic [15:0]      sw,
    output logic [15:0]      led
);

    logic [15:0] led_q, led_d;
    logic [15:0] sw_meta_q, sw_meta_d;
    logic [15:0] sw_sync_q, sw_sync_d;
    logic [31:0] cyc_q, cyc_d;

    always_comb begin
        led_d     = led_q;
        sw_meta_d = sw;
        sw_sync_d = sw_meta_q;
        cyc_d     = cyc_q + 32'd1;          // wraps naturally at 2^32-1
        if (wr_en && (wr_sel == MMIO_LED)) begin
            led_d = wdata;
        end
        // A clear overrides the increment in the same cycle.
        if (wr_en && (wr_sel == MMIO_CYC)) begin
            cyc_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_q     <= '0;
            sw_meta_q <= '0;
            sw_sync_q <= '0;
            cyc_q     <= '0;
        end else begin
            led_q     <= led_d;
            sw_meta_q <= sw_meta_d;
            sw_sync_q <= sw_sync_d;
            cyc_q     <= cyc_d;
        end
    end

    always_comb begin
        rdata = '0;
        case (rd_sel)
            MMIO_LED: rdata = {16'h0000, led_q};
            MMIO_SW:  rdata = {16'h0000, sw_sync_q};
            MMIO_CYC: rdata = cyc_q;
            default:  rdata = '0;
        endcase
    end

    assign led = led_q;

endmodule

// File: rtl/bus_mem_slave.sv
// ---------------------------------------------------------------------------
// bus_mem_slave
// Responder on the CPU shared memory bus. Each request is decoded to a word
// RAM or to the MMIO window (LED, switches, cycle counter). Reads are served
// by driving the tristate BUS for one cycle together with Ready; writes are
// sampled from BUS at accept and committed when the RESP cycle ends.
// Optional wait states stretch the time between accept and Ready.
// Ports:
//   clk, rst  clock and asynchronous active-high reset
//   BUS       shared 32-bit data bus, driven only during a read's RESP cycle
//   Memread   read request, held until Ready
//   Memwrite  write request, held until Ready, data on BUS
//   Addr      byte address (word aligned)
//   Ready     one-cycle pulse marking transaction done / read data valid
//   sw        board switches (readable via MMIO)
//   led       LED register (writable via MMIO)
//   err       sticky protocol error (both requests, or misaligned address)
// ---------------------------------------------------------------------------
module bus_mem_slave
    import bus_pkg::*;
#(
    parameter int          ADDR_BITS   = 10,
    parameter int          WAIT_STATES = 0,
    parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000,
    parameter string       INIT_FILE   = ""
) (
    input  logic             clk,
    input  logic             rst,
    inout  wire  [BUS_W-1:0] BUS,
    input  logic             Memread,
    input  logic             Memwrite,
    input  logic [31:0]      Addr,
    output logic             Ready,
    input  logic [15:0]      sw,
    output logic [15:0]      led,
    output logic             err
);

    localparam int         RAM_DEPTH = 2 ** ADDR_BITS;
    localparam bit         HAS_WAIT  = (WAIT_STATES > 0);
    localparam logic [3:0] WAIT_LOAD = HAS_WAIT ? 4'(WAIT_STATES - 1) : 4'd0;

    // ---------------- state ----------------
    state_e                 state_q, state_d;
    op_e                    op_q, op_d;
    logic [31:0]            addr_q, addr_d;
    logic [BUS_W-1:0]       wdata_q, wdata_d;
    logic [3:0]             wait_cnt_q, wait_cnt_d;
    logic                   err_q, err_d;
    rsrc_e                  rsrc_q, rsrc_d;
    logic [BUS_W-1:0]       mmio_rdata_q, mmio_rdata_d;
    logic [BUS_W-1:0]       ram_rdata_q;

    // ---------------- combinational ----------------
    logic                   req_one, req_both;
    logic                   enter_resp;
    logic [31:0]            rd_addr;
    logic                   rd_is_mmio, rd_misaligned;
    logic                   wr_is_mmio, commit, ram_we, mmio_we;
    logic [ADDR_BITS-1:0]   rd_idx, wr_idx;
    logic [BUS_W-1:0]       mmio_rdata, resp_data;

    logic [BUS_W-1:0]       ram_q [RAM_DEPTH];

    assign req_one  = Memread ^ Memwrite;
    assign req_both = Memread & Memwrite;

    // Read data is captured on the edge that enters RESP. With no wait
    // states that edge is the accept edge itself, so the address must come
    // straight from Addr; otherwise the latched address is used.
    assign rd_addr       = (state_q == S_IDLE) ? Addr : addr_q;
    assign rd_is_mmio    = (rd_addr[31:4] == MMIO_BASE[31:4]);
    assign rd_misaligned = (rd_addr[1:0] != 2'b00);
    assign rd_idx        = rd_addr[ADDR_BITS+1:2];

    assign wr_is_mmio = (addr_q[31:4] == MMIO_BASE[31:4]);
    assign wr_idx     = addr_q[ADDR_BITS+1:2];
    // Writes land on the RESP->IDLE edge; misaligned writes are dropped.
    assign commit     = (state_q == S_RESP) && (op_q == OP_WR) && (addr_q[1:0] == 2'b00);
    assign ram_we     = commit && !wr_is_mmio;
    assign mmio_we    = commit && wr_is_mmio;

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wait_cnt_d   = wait_cnt_q;
        err_d        = err_q;
        rsrc_d       = rsrc_q;
        mmio_rdata_d = mmio_rdata_q;
        enter_resp   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_both) begin
                    err_d = 1'b1;
                end else if (req_one) begin
                    op_d       = Memwrite ? OP_WR : OP_RD;
                    addr_d     = Addr;
                    wdata_d    = BUS;
                    wait_cnt_d = WAIT_LOAD;
                    if (Addr[1:0] != 2'b00) begin
                        err_d = 1'b1;
                    end
                    if (HAS_WAIT) begin
                        state_d = S_WAIT;
                    end else begin
                        state_d    = S_RESP;
                        enter_resp = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                // The request may already be gone here; the latched values
                // carry the transaction to completion regardless.
                if (wait_cnt_q == 4'd0) begin
                    state_d    = S_RESP;
                    enter_resp = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (enter_resp) begin
            mmio_rdata_d = mmio_rdata;
            if (rd_misaligned) begin
                rsrc_d = SRC_ZERO;
            end else if (rd_is_mmio) begin
                rsrc_d = SRC_MMIO;
            end else begin
                rsrc_d = SRC_RAM;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            op_q         <= OP_RD;
            addr_q       <= '0;
            wdata_q      <= '0;
            wait_cnt_q   <= '0;
            err_q        <= 1'b0;
            rsrc_q       <= SRC_ZERO;
            mmio_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wait_cnt_q   <= wait_cnt_d;
            err_q        <= err_d;
            rsrc_q       <= rsrc_d;
            mmio_rdata_q <= mmio_rdata_d;
        end
    end

    // ---------------- word RAM (contents survive reset) ----------------
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram_q[wr_idx] <= wdata_q;
        end
        if (enter_resp) begin
            ram_rdata_q <= ram_q[rd_idx];
        end
    end

    // ---------------- MMIO registers ----------------
    bus_mmio_regs u_mmio (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (mmio_we),
        .wr_sel (addr_q[3:0]),
        .wdata  (wdata_q[15:0]),
        .rd_sel (rd_addr[3:0]),
        .rdata  (mmio_rdata),
        .sw     (sw),
        .led    (led)
    );

    // ---------------- bus side ----------------
    always_comb begin
        resp_data = '0;
        case (rsrc_q)
            SRC_RAM:  resp_data = ram_rdata_q;
            SRC_MMIO: resp_data = mmio_rdata_q;
            default:  resp_data = '0;
        endcase
    end

    // Driven only in a read's RESP cycle; during writes the requester owns BUS.
    assign BUS   = ((state_q == S_RESP) && (op_q == OP_RD)) ? resp_data : 'z;
    assign Ready = (state_q == S_RESP);
    assign err   = err_q;

endmodule
